// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [3:0] {
        LB  = 4'h0,
        LH  = 4'h1,
        LW  = 4'h2,
        LBU = 4'h4,
        LHU = 4'h5,
        SB  = 4'h8,
        SH  = 4'h9,
        SW  = 4'hA
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_e;

    // funct3[1:0] -> access size in bytes; 0 for the unused encoding.
    function automatic logic [2:0] access_size(input logic [1:0] size_code);
        case (size_code)
            2'd0:    access_size = 3'd1;
            2'd1:    access_size = 3'd2;
            2'd2:    access_size = 3'd4;
            default: access_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-result extension from an address-aligned memory word.
module lsu_extend (
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        data = '0;
        case (funct3)
            3'd0:    data = {{24{raw[7]}}, raw[7:0]};
            3'd1:    data = {{16{raw[15]}}, raw[15:0]};
            3'd2:    data = raw;
            3'd4:    data = {24'd0, raw[7:0]};
            3'd5:    data = {16'd0, raw[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator driving the unified memory data port.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_fault,
    output logic [ADDR_WIDTH-1:0] mem_fetch_addr,
    input  logic [DATA_WIDTH-1:0] mem_fetched_data,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [2:0]            mem_bytes_to_write
);

    lsu_state_e            state_q, state_d;
    logic [3:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  fault_q;
    logic [DATA_WIDTH-1:0] ext_data;
    logic [2:0]            req_size;
    logic                  req_illegal;
    logic                  req_misaligned;
    logic                  req_fault;

    lsu_extend u_extend (
        .funct3 (op_q[2:0]),
        .raw    (mem_fetched_data),
        .data   (ext_data)
    );

    always_comb begin
        req_size    = access_size(req_op[1:0]);
        req_illegal = req_op[3] ? (req_op[2:0] > 3'd2)
                                : (req_op[2:0] == 3'd3 || req_op[2:0] == 3'd6 ||
                                   req_op[2:0] == 3'd7);
        req_misaligned = !ALLOW_MISALIGNED &&
                         ((req_size == 3'd2 && req_addr[0]) ||
                          (req_size == 3'd4 && req_addr[1:0] != 2'b00));
        req_fault = req_illegal || req_misaligned;
    end

    always_comb begin
        state_d            = state_q;
        req_ready          = 1'b0;
        rsp_valid          = 1'b0;
        mem_bytes_to_write = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = req_fault ? RESP : ACCESS;
            end
            ACCESS: begin
                // Gated by rst so a store caught by reset never commits.
                if (op_q[3] && !rst)
                    mem_bytes_to_write = access_size(op_q[1:0]);
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                fault_q <= req_fault;
            end else if (state_q == ACCESS && !op_q[3]) begin
                rdata_q <= ext_data;
            end
        end
    end

    assign rsp_rdata      = rdata_q;
    assign rsp_fault      = fault_q;
    assign mem_fetch_addr = addr_q;
    assign mem_write_addr = addr_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_fetch_addr;
    logic [31:0] mem_fetched_data;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_bytes_to_write;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    logic [7:0] mem [0:4095];

    always #5 clk = ~clk;

    load_store_unit #(
        .ADDR_WIDTH       (32),
        .DATA_WIDTH       (32),
        .ALLOW_MISALIGNED (1'b0)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_op             (req_op),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_rdata          (rsp_rdata),
        .rsp_fault          (rsp_fault),
        .mem_fetch_addr     (mem_fetch_addr),
        .mem_fetched_data   (mem_fetched_data),
        .mem_write_addr     (mem_write_addr),
        .mem_write_data     (mem_write_data),
        .mem_bytes_to_write (mem_bytes_to_write)
    );

    // Memory model: combinational little-endian read, byte writes on the clock edge.
    logic [11:0] ra;
    logic [11:0] wa;
    assign ra = mem_fetch_addr[11:0];
    assign wa = mem_write_addr[11:0];
    assign mem_fetched_data = {mem[ra + 12'd3], mem[ra + 12'd2], mem[ra + 12'd1], mem[ra]};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (i < int'(mem_bytes_to_write))
                mem[wa + 12'(i)] <= mem_write_data[8*i +: 8];
        if (mem_bytes_to_write != 3'd0)
            wr_count <= wr_count + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic fault, output int lat,
                          output int writes, output logic [31:0] faddr);
        int w0;
        w0        = wr_count;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        faddr     = mem_fetch_addr;
        lat       = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        fault = rsp_fault;
        @(posedge clk); #1;
        writes = wr_count - w0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
    } vec_t;

    vec_t vecs [24];

    initial begin
        logic [31:0] rd;
        logic [31:0] fa;
        logic        ft;
        int          lat;
        int          wr;
        int          w0;

        vecs[0]  = '{4'hA, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{4'h2, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{4'h0, 32'h103, 32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{4'h4, 32'h103, 32'h0,        32'h000000DE, 1'b0};
        vecs[4]  = '{4'h1, 32'h102, 32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[5]  = '{4'h5, 32'h100, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[6]  = '{4'h9, 32'h101, 32'h00001234, 32'h0,        1'b1};
        vecs[7]  = '{4'h2, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[8]  = '{4'hB, 32'h100, 32'h11111111, 32'h0,        1'b1};
        vecs[9]  = '{4'h3, 32'h100, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{4'h6, 32'h100, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{4'h7, 32'h100, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{4'hC, 32'h100, 32'h22222222, 32'h0,        1'b1};
        vecs[13] = '{4'h2, 32'h102, 32'h0,        32'h0,        1'b1};
        vecs[14] = '{4'h1, 32'h103, 32'h0,        32'h0,        1'b1};
        vecs[15] = '{4'h8, 32'h105, 32'hFFFFFFA5, 32'h0,        1'b0};
        vecs[16] = '{4'h4, 32'h105, 32'h0,        32'h000000A5, 1'b0};
        vecs[17] = '{4'h0, 32'h105, 32'h0,        32'hFFFFFFA5, 1'b0};
        vecs[18] = '{4'h9, 32'h106, 32'hABCD8001, 32'h0,        1'b0};
        vecs[19] = '{4'h1, 32'h106, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[20] = '{4'h5, 32'h106, 32'h0,        32'h00008001, 1'b0};
        vecs[21] = '{4'h2, 32'h104, 32'h0,        32'h8001A500, 1'b0};
        vecs[22] = '{4'h2, 32'h108, 32'h0,        32'h00000000, 1'b0};
        vecs[23] = '{4'h0, 32'h100, 32'h0,        32'hFFFFFFEF, 1'b0};

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'h0D; mem[12'h201] = 8'hF0;
        mem[12'h202] = 8'hFE; mem[12'h203] = 8'hCA;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_fault", 32'(rsp_fault), 32'd0);
        chk("reset bytes", 32'(mem_bytes_to_write), 32'd0);
        chk("reset fetch_addr", mem_fetch_addr, 32'd0);
        chk("reset write_addr", mem_write_addr, 32'd0);
        chk("reset write_data", mem_write_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, ft, lat, wr, fa);
            chk($sformatf("v%0d rdata", i), rd, vecs[i].rdata);
            chk($sformatf("v%0d fault", i), 32'(ft), 32'(vecs[i].fault));
            chk($sformatf("v%0d latency", i), 32'(lat), vecs[i].fault ? 32'd1 : 32'd2);
            chk($sformatf("v%0d writes", i), 32'(wr),
                (vecs[i].op[3] && !vecs[i].fault) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d fetch_addr", i), fa, vecs[i].addr);
            chk($sformatf("v%0d req_ready after", i), 32'(req_ready), 32'd1);
        end

        // Backpressure: hold the LW response for five cycles.
        rsp_ready = 1'b0;
        req_op    = 4'h2;
        req_addr  = 32'h100;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d rdata", c), rsp_rdata, 32'hDEADBEEF);
            chk($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d bytes", c), 32'(mem_bytes_to_write), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release req_ready", 32'(req_ready), 32'd1);
        chk("bp release rsp_valid", 32'(rsp_valid), 32'd0);

        // Reset landing on the ACCESS cycle of a store.
        w0        = wr_count;
        req_op    = 4'hA;
        req_addr  = 32'h200;
        req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst-store access bytes", 32'(mem_bytes_to_write), 32'd4);
        rst = 1'b1;
        #1;
        chk("rst-store gated bytes", 32'(mem_bytes_to_write), 32'd0);
        @(posedge clk); #1;
        chk("rst-store writes", 32'(wr_count - w0), 32'd0);
        chk("rst-store req_ready", 32'(req_ready), 32'd1);
        chk("rst-store rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst-store rsp_rdata", rsp_rdata, 32'd0);
        chk("rst-store rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst-store fetch_addr", mem_fetch_addr, 32'd0);
        chk("rst-store write_data", mem_write_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        do_req(4'h2, 32'h200, 32'h0, rd, ft, lat, wr, fa);
        chk("post-rst LW 0x200 rdata", rd, 32'hCAFEF00D);
        chk("post-rst LW 0x200 fault", 32'(ft), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
